// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared definitions for the pulse train generator slice.
//   state_t    - controller states (IDLE, PULSE, GAP, DONE)
//   CNT_W_DEF  - default width of the pulse-count path
//   GAP_W_DEF  - default width of the gap path
//   GAP_MIN    - smallest gap ever used; a programmed gap of 0 maps to it
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned CNT_W_DEF = 3;
    localparam int unsigned GAP_W_DEF = 3;
    localparam int unsigned GAP_MIN   = 1;

    // Effective gap: a programmed gap of zero becomes GAP_MIN so pulses never merge.
    function automatic logic [31:0] effective_gap(input logic [31:0] g);
        return (g == 32'd0) ? 32'(GAP_MIN) : g;
    endfunction

endpackage

// File: rtl/pulse_generator_if.sv
// pulse_generator_if: request/status bundle of the pulse train generator.
//   start       - one-cycle request (driven by master)
//   pulse_count - number of pulses N (driven by master)
//   gap         - low cycles G between pulses (driven by master)
//   pulse       - one-cycle pulse per emitted pulse (driven by slave)
//   busy        - train in progress (driven by slave)
//   done        - one-cycle completion strobe (driven by slave)
interface pulse_generator_if #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned GAP_W = 3
);

    logic             start;
    logic [CNT_W-1:0] pulse_count;
    logic [GAP_W-1:0] gap;
    logic             pulse;
    logic             busy;
    logic             done;

    modport master (
        output start, pulse_count, gap,
        input  pulse, busy, done
    );

    modport slave (
        input  start, pulse_count, gap,
        output pulse, busy, done
    );

endinterface

// File: rtl/pulse_generator_down_counter.sv
// down_counter: loadable down counter of parameterised width.
//   clock      - system clock
//   reset      - synchronous active-high reset, clears the count
//   load       - load load_value (has priority over enable)
//   load_value - value to load
//   enable     - decrement by one; holds at zero instead of wrapping
//   count      - current count
//   is_one     - count equals one (last step before exhausting)
module down_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/pulse_generator.sv
// pulse_generator: emits N single-cycle pulses separated by Ge low cycles,
// where Ge = (gap == 0) ? 1 : gap, then a one-cycle done strobe.
//   clock - system clock, all state updates on posedge
//   reset - synchronous active-high reset; abandons any train silently
//   bus   - slave side of pulse_generator_if (start/pulse_count/gap in,
//           pulse/busy/done out, all outputs registered)
module pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned GAP_W = GAP_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    pulse_generator_if.slave   bus
);

    state_t           state;
    state_t           state_nxt;

    logic             accept;
    logic             rem_en;
    logic             rem_is_one;
    logic [CNT_W-1:0] rem_count;

    logic             gcnt_load;
    logic             gcnt_en;
    logic             gcnt_is_one;
    logic [GAP_W-1:0] gcnt_count;

    logic [GAP_W-1:0] ge_q;
    logic [GAP_W-1:0] ge_in;

    logic             pulse_q;
    logic             busy_q;
    logic             done_q;

    assign ge_in = GAP_W'(effective_gap(32'(bus.gap)));

    down_counter #(.WIDTH(CNT_W)) u_rem (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (bus.pulse_count),
        .enable     (rem_en),
        .count      (rem_count),
        .is_one     (rem_is_one)
    );

    down_counter #(.WIDTH(GAP_W)) u_gcnt (
        .clock      (clock),
        .reset      (reset),
        .load       (gcnt_load),
        .load_value (ge_q),
        .enable     (gcnt_en),
        .count      (gcnt_count),
        .is_one     (gcnt_is_one)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rem_en    = 1'b0;
        gcnt_load = 1'b0;
        gcnt_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.pulse_count != '0) begin
                        accept    = 1'b1;
                        state_nxt = PULSE;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            PULSE: begin
                rem_en = 1'b1;
                if (rem_is_one) begin
                    state_nxt = DONE;
                end else begin
                    gcnt_load = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                gcnt_en = 1'b1;
                if (gcnt_is_one) begin
                    state_nxt = PULSE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they are aligned with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ge_q    <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            if (accept) begin
                ge_q <= ge_in;
            end
            pulse_q <= (state_nxt == PULSE);
            busy_q  <= (state_nxt == PULSE) || (state_nxt == GAP);
            done_q  <= (state_nxt == DONE);
        end
    end

    assign bus.pulse = pulse_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // Counters must never be exhausted while they are still being consumed.
    a_rem_live: assert property (@(posedge clock) disable iff (reset)
        (state == PULSE) |-> (rem_count != '0));
    a_gcnt_live: assert property (@(posedge clock) disable iff (reset)
        (state == GAP) |-> (gcnt_count != '0));
    a_pulse_busy: assert property (@(posedge clock) disable iff (reset)
        bus.pulse |-> bus.busy);
    a_done_idle: assert property (@(posedge clock) disable iff (reset)
        bus.done |-> !bus.busy);

endmodule

// File: tb/tb_pulse_generator.sv
module tb_pulse_generator;

    logic clock;
    logic reset;

    int unsigned n_pass;
    int unsigned n_total;

    pulse_generator_if #(.CNT_W(3), .GAP_W(3)) bus ();

    pulse_generator #(.CNT_W(3), .GAP_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One record: inputs held during a cycle, {pulse,busy,done} expected in the next one.
    typedef struct {
        logic       start;
        logic [2:0] pc;
        logic [2:0] gap;
        logic [2:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] exp);
        logic [2:0] got;
        got = {bus.pulse, bus.busy, bus.done};
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: pulse/busy/done got %b expected %b", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Expected {pulse,busy,done} in cycle t of a train started at cycle 0.
    function automatic logic [2:0] train_exp(input int t, input int n, input int ge);
        int last;
        logic p, b, d;
        last = 1 + (n - 1) * (ge + 1);
        p = (t >= 1) && (t <= last) && (((t - 1) % (ge + 1)) == 0);
        b = (t >= 1) && (t <= last);
        d = (t == last + 1);
        return {p, b, d};
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{1'b1, 3'd3, 3'd2, 3'b110, "A c1"};
        vecs[1]  = '{1'b0, 3'd7, 3'd0, 3'b010, "A c2"};
        vecs[2]  = '{1'b0, 3'd1, 3'd5, 3'b010, "A c3"};
        vecs[3]  = '{1'b1, 3'd0, 3'd0, 3'b110, "A c4"};
        vecs[4]  = '{1'b0, 3'd0, 3'd0, 3'b010, "A c5"};
        vecs[5]  = '{1'b0, 3'd0, 3'd0, 3'b010, "A c6"};
        vecs[6]  = '{1'b1, 3'd0, 3'd0, 3'b110, "A c7"};
        vecs[7]  = '{1'b0, 3'd0, 3'd0, 3'b001, "A c8 done"};
        vecs[8]  = '{1'b1, 3'd2, 3'd2, 3'b000, "A c9 idle"};
        vecs[9]  = '{1'b1, 3'd0, 3'd5, 3'b001, "B N0 done"};
        vecs[10] = '{1'b0, 3'd0, 3'd5, 3'b000, "B idle"};
        vecs[11] = '{1'b1, 3'd2, 3'd0, 3'b110, "C c1"};
        vecs[12] = '{1'b0, 3'd0, 3'd0, 3'b010, "C c2"};
        vecs[13] = '{1'b0, 3'd0, 3'd0, 3'b110, "C c3"};
        vecs[14] = '{1'b0, 3'd0, 3'd0, 3'b001, "C c4 done"};
        vecs[15] = '{1'b0, 3'd0, 3'd0, 3'b000, "C idle"};

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.pulse_count = '0;
        bus.gap         = '0;
        step();
        step();
        check("reset", 3'b000);
        reset = 1'b0;
        step();
        check("post-reset idle", 3'b000);

        for (int i = 0; i < 16; i++) begin
            bus.start       = vecs[i].start;
            bus.pulse_count = vecs[i].pc;
            bus.gap         = vecs[i].gap;
            step();
            check(vecs[i].name, vecs[i].exp);
        end

        // Max N and gap; inputs change mid-train and must be ignored.
        bus.start       = 1'b1;
        bus.pulse_count = 3'd7;
        bus.gap         = 3'd7;
        for (int t = 1; t <= 52; t++) begin
            step();
            bus.start = 1'b0;
            if (t == 3) begin
                bus.pulse_count = 3'd1;
                bus.gap         = 3'd0;
            end
            check($sformatf("max t%0d", t), train_exp(t, 7, 7));
        end

        // Start held high: no queueing, restart only once back in IDLE.
        bus.start       = 1'b1;
        bus.pulse_count = 3'd4;
        bus.gap         = 3'd1;
        for (int t = 1; t <= 9; t++) begin
            step();
            check($sformatf("hold t%0d", t), train_exp(t, 4, 1));
        end
        step();
        bus.start = 1'b0;
        check("hold t10 restart", 3'b110);
        for (int t = 11; t <= 19; t++) begin
            step();
            check($sformatf("hold t%0d", t), train_exp(t - 9, 4, 1));
        end

        // Reset mid-train: silent abort, then a fresh start works normally.
        bus.start       = 1'b1;
        bus.pulse_count = 3'd5;
        bus.gap         = 3'd2;
        for (int t = 1; t <= 5; t++) begin
            step();
            bus.start = 1'b0;
            check($sformatf("rst pre t%0d", t), train_exp(t, 5, 2));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst t6", 3'b000);
        for (int t = 7; t <= 20; t++) begin
            step();
            check($sformatf("rst quiet t%0d", t), 3'b000);
        end
        bus.start       = 1'b1;
        bus.pulse_count = 3'd1;
        bus.gap         = 3'd3;
        step();
        bus.start = 1'b0;
        check("rst restart pulse", 3'b110);
        step();
        check("rst restart done", 3'b001);
        step();
        check("rst restart idle", 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
- Emits a programmable train of single-cycle pulses: N pulses separated by G low cycles, started by a one-cycle start request.
- It is the producing end of the event-counting path. Its pulse output is intended to drive clock-enable/count inputs of counter blocks, and its done output feeds the FSMs that wait on them.
- Request/status handshake: start in, busy/done out.

Parameters:
- CNT_W, 3, width of pulse_count and of the internal remaining-pulse counter
- GAP_W, 3, width of gap and of the internal gap counter

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- pulse_count  input  CNT_W  number of pulses N to emit; latched on accepted start
- gap  input  GAP_W  low cycles G between pulses; latched on accepted start
- pulse  output  1  registered; high for exactly one cycle per emitted pulse
- busy  output  1  registered; high while a train is in progress
- done  output  1  registered; one-cycle completion strobe

Behaviour:
- Reset: one clock and one synchronous active-high reset. On a posedge with reset=1:
  - state goes to IDLE;
  - pulse, busy and done go to 0;
  - internal counters go to 0.
- Reset has priority over every other input, including mid-train. The train is abandoned and no done strobe is issued.
- All outputs are registered. Nothing is combinational from the inputs.
- Latching: pulse_count and gap are captured only at an accepted start. Changes to them while busy have no effect.
- Effective gap Ge = (gap==0) ? 1 : gap. Pulses therefore never merge.
- State IDLE: busy=0, pulse=0, done=0.
  - start=1 and pulse_count!=0: latch rem=pulse_count and Ge, then go to PULSE.
  - start=1 and pulse_count==0: go to DONE. No pulse is emitted.
  - start=0: stay in IDLE.
- State PULSE (lasts one cycle): pulse=1, busy=1. rem decrements.
  - rem was 1: go to DONE.
  - otherwise: load gcnt=Ge and go to GAP.
- State GAP: pulse=0, busy=1. gcnt decrements each cycle. When gcnt reaches 1, go to PULSE on the next edge, so exactly Ge low cycles occur.
- State DONE (lasts one cycle): done=1, busy=0, pulse=0. Go to IDLE.
- start handling outside IDLE: start is ignored in PULSE, GAP and DONE. It is not queued. A new train needs start in IDLE, so the earliest restart is the cycle after done.
- Latency: with start sampled at edge k:
  - first pulse is high in cycle k+1;
  - pulse i (1-based) is high in cycle k+1+(i-1)(Ge+1);
  - done is high in cycle k+1+(N-1)(Ge+1)+1;
  - busy is high from cycle k+1 through the last pulse cycle inclusive.
- Width rules:
  - rem and gcnt are unsigned and never wrap below 0; the FSM leaves PULSE/GAP before decrementing past 1.
  - maxima: N=2^CNT_W-1 and G=2^GAP_W-1.
- Invariants: pulse implies busy, and done implies not busy.

Decomposition:
- Shared package pulse_gen_pkg holds:
  - state typedef {IDLE, PULSE, GAP, DONE};
  - default CNT_W and GAP_W constants;
  - the GAP_MIN=1 constant.
- One natural sub-module: down_counter. It provides a loadable, parameterised-width decrementer with load, enable and is_one outputs. It is instantiated twice, once for rem and once for gcnt.

Test Plan:
- N=3, gap=2, start pulsed at cycle 0 -> pulse high in cycles 1, 4 and 7; busy high cycles 1–7; done high in cycle 8 only; idle from cycle 9.
- N=0, gap=5, start at cycle 0 -> no pulse; busy never high; done high in cycle 1.
- N=2, gap=0 -> pulses in cycles 1 and 3 (Ge=1); done in cycle 4.
- N=7, gap=7, with start at 0 and pulse_count changed to 1 at cycle 3 -> 7 pulses at cycles 1, 9, …, 49; done at 50. The input change has no effect.
- N=4, gap=1, start re-asserted every cycle -> exactly 4 pulses (1, 3, 5, 7) and done at 8. A new train starts only if start is sampled in IDLE at cycle 9, giving its first pulse at 10.
- N=5, gap=2, reset asserted for one edge at cycle 5 -> pulse, busy and done are 0 from cycle 6. No done strobe follows, no further pulses occur, and a subsequent start behaves as from power-up.
